// File: rtl/assoc_cache_if.sv
// CPU request/response and memory refill/write-through bundle for assoc_cache.
// slave = cache side, master = CPU/memory side.
interface assoc_cache_if #(
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 4
);
  logic                         req_valid;
  logic                         req_write;
  logic [WORD_W-1:0]            req_addr;
  logic [WORD_W-1:0]            req_wdata;
  logic                         req_ready;
  logic                         resp_valid;
  logic [WORD_W-1:0]            resp_rdata;
  logic                         resp_hit;
  logic                         mem_rd_req;
  logic                         mem_wr_req;
  logic [WORD_W-1:0]            mem_addr;
  logic [WORD_W-1:0]            mem_wdata;
  logic [WORD_W*LINE_WORDS-1:0] mem_rdata;
  logic                         mem_ready;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_rd_req, mem_wr_req, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_rd_req, mem_wr_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/assoc_cache.sv
// N-way set-associative write-through, no-write-allocate cache with true-LRU ages.
// Define ASSOC_CACHE_STATS_EN to enable the saturating access/hit counters.
module assoc_cache #(
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 4,
  parameter int WAYS       = 2,
  parameter int SETS       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  assoc_cache_if.slave      bus,
  output logic [WORD_W-1:0] access_cnt,
  output logic [WORD_W-1:0] hit_cnt
);
  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int IDX_BITS = $clog2(SETS);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_W    = WORD_W - OFF_W - IDX_BITS;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W   = WORD_W * LINE_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  function automatic logic [IDX_W-1:0] f_idx(input logic [WORD_W-1:0] a);
    return IDX_W'((a >> OFF_W) & WORD_W'(SETS - 1));
  endfunction

  function automatic logic [TAG_W-1:0] f_tag(input logic [WORD_W-1:0] a);
    return TAG_W'(a >> (OFF_W + IDX_BITS));
  endfunction

  function automatic logic [OFF_W-1:0] f_off(input logic [WORD_W-1:0] a);
    return OFF_W'(a);
  endfunction

  state_t             r_state, w_state_next;
  logic [SETS-1:0]    r_valid [WAYS];
  logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
  logic [LINE_W-1:0]  r_data  [WAYS][SETS];

  logic [WORD_W-1:0]  r_addr;
  logic               r_hit;
  logic               r_resp_valid;
  logic [WORD_W-1:0]  r_resp_rdata;
  logic               r_resp_hit;
  logic [WORD_W-1:0]  r_mem_addr;
  logic [WORD_W-1:0]  r_mem_wdata;

  logic [IDX_W-1:0]   w_idx, w_r_idx, w_touch_set;
  logic [TAG_W-1:0]   w_tag;
  logic [OFF_W-1:0]   w_off, w_r_off;
  logic [WAYS-1:0]    w_hit_vec;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way, w_victim, w_touch_way;
  logic [LINE_W-1:0]  w_hit_line;
  logic               w_accept, w_fill, w_write_done, w_touch;

  assign w_idx   = f_idx(bus.req_addr);
  assign w_tag   = f_tag(bus.req_addr);
  assign w_off   = f_off(bus.req_addr);
  assign w_r_idx = f_idx(r_addr);
  assign w_r_off = f_off(r_addr);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_lookup
    assign w_hit_vec[gi] = r_valid[gi][w_idx] && (r_tag[gi][w_idx] == w_tag);
  end

  always_comb begin
    w_hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
    end
  end

  assign w_hit        = |w_hit_vec;
  assign w_hit_line   = r_data[w_hit_way][w_idx];
  assign w_accept     = bus.req_valid && (r_state == S_IDLE);
  assign w_fill       = (r_state == S_REFILL) && bus.mem_ready;
  assign w_write_done = (r_state == S_WRITE) && bus.mem_ready;
  assign w_touch      = (w_accept && w_hit) || w_fill;
  assign w_touch_set  = w_fill ? w_r_idx : w_idx;
  assign w_touch_way  = w_fill ? w_victim : w_hit_way;

  if (WAYS > 1) begin : g_lru
    logic [WAY_W-1:0] r_age [SETS][WAYS];
    logic             w_found;

    // Ages form a permutation per set; the oldest (WAYS-1) is the LRU way.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int s = 0; s < SETS; s++)
          for (int i = 0; i < WAYS; i++)
            r_age[s][i] <= WAY_W'(i);
      end else if (w_touch) begin
        for (int j = 0; j < WAYS; j++) begin
          if (WAY_W'(j) == w_touch_way)
            r_age[w_touch_set][j] <= '0;
          else if (r_age[w_touch_set][j] < r_age[w_touch_set][w_touch_way])
            r_age[w_touch_set][j] <= r_age[w_touch_set][j] + 1'b1;
        end
      end
    end

    always_comb begin
      w_victim = '0;
      w_found  = 1'b0;
      for (int i = 0; i < WAYS; i++) begin
        if (!w_found && !r_valid[i][w_r_idx]) begin
          w_victim = WAY_W'(i);
          w_found  = 1'b1;
        end
      end
      if (!w_found) begin
        for (int i = 0; i < WAYS; i++) begin
          if (r_age[w_r_idx][i] == WAY_W'(WAYS - 1)) w_victim = WAY_W'(i);
        end
      end
    end
  end else begin : g_no_lru
    assign w_victim = '0;
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_victim][w_r_idx] <= bus.mem_rdata;
      r_tag[w_victim][w_r_idx]  <= f_tag(r_addr);
    end else if (w_accept && bus.req_write && w_hit) begin
      r_data[w_hit_way][w_idx][w_off*WORD_W +: WORD_W] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WAYS; i++) r_valid[i] <= '0;
    end else if (w_fill) begin
      r_valid[w_victim][w_r_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    bus.req_ready  = 1'b0;
    bus.mem_rd_req = 1'b0;
    bus.mem_wr_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) begin
          if (bus.req_write)  w_state_next = S_WRITE;
          else if (!w_hit)    w_state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        bus.mem_rd_req = 1'b1;
        if (bus.mem_ready) w_state_next = S_IDLE;
      end
      S_WRITE: begin
        bus.mem_wr_req = 1'b1;
        if (bus.mem_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_hit        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_hit   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_addr <= bus.req_addr;
        r_hit  <= w_hit;
        if (bus.req_write) begin
          r_mem_addr  <= bus.req_addr;
          r_mem_wdata <= bus.req_wdata;
        end else if (w_hit) begin
          r_resp_valid <= 1'b1;
          r_resp_hit   <= 1'b1;
          r_resp_rdata <= w_hit_line[w_off*WORD_W +: WORD_W];
        end else begin
          r_mem_addr <= bus.req_addr & ~WORD_W'(LINE_WORDS - 1);
        end
      end
      if (w_fill) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= 1'b0;
        r_resp_rdata <= bus.mem_rdata[w_r_off*WORD_W +: WORD_W];
      end
      if (w_write_done) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= r_hit;
        r_resp_rdata <= '0;
      end
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_hit   = r_resp_hit;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;

`ifdef ASSOC_CACHE_STATS_EN
  logic [WORD_W-1:0] r_access_cnt, r_hit_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_access_cnt <= '0;
      r_hit_cnt    <= '0;
    end else if (w_accept) begin
      if (r_access_cnt != '1)       r_access_cnt <= r_access_cnt + 1'b1;
      if (w_hit && r_hit_cnt != '1) r_hit_cnt    <= r_hit_cnt + 1'b1;
    end
  end

  assign access_cnt = r_access_cnt;
  assign hit_cnt    = r_hit_cnt;
`else
  assign access_cnt = '0;
  assign hit_cnt    = '0;
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (16-bit words, 4-word lines, 2 ways, 4 sets).
// Memory word at address a initially holds a + 0xC0; write-throughs update it.
module tb_assoc_cache;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] access_cnt, hit_cnt;
  logic [15:0] mem [0:2047];
  int          n_pass = 0;
  int          n_total = 0;

  assoc_cache_if #(.WORD_W(16), .LINE_WORDS(4)) bus ();

  assoc_cache #(.WORD_W(16), .LINE_WORDS(4), .WAYS(2), .SETS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .access_cnt (access_cnt),
    .hit_cnt    (hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle mem_ready strobe serving the outstanding request.
  task automatic mem_serve();
    logic [15:0] b;
    b = bus.mem_addr;
    if (bus.mem_wr_req) mem[b[10:0]] = bus.mem_wdata;
    bus.mem_rdata = {mem[b[10:0]+11'd3], mem[b[10:0]+11'd2], mem[b[10:0]+11'd1], mem[b[10:0]]};
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic exp_hit,
                         input logic [15:0] exp_d, input int delay);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    chk({tag, ".req_ready"}, bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 16'hFFFF;
    if (exp_hit) begin
      chk({tag, ".resp_valid"}, bus.resp_valid, 1);
      chk({tag, ".resp_hit"},   bus.resp_hit, 1);
      chk({tag, ".rdata"},      bus.resp_rdata, exp_d);
      chk({tag, ".no_mem"},     bus.mem_rd_req, 0);
    end else begin
      chk({tag, ".mem_rd_req"}, bus.mem_rd_req, 1);
      chk({tag, ".mem_addr"},   bus.mem_addr, a & 16'hFFFC);
      chk({tag, ".busy"},       bus.req_ready, 0);
      for (int i = 0; i < delay; i++) begin
        tick();
        chk({tag, ".held"}, {bus.mem_rd_req, bus.req_ready, bus.resp_valid}, 3'b100);
      end
      mem_serve();
      chk({tag, ".resp_valid"}, bus.resp_valid, 1);
      chk({tag, ".resp_hit"},   bus.resp_hit, 0);
      chk({tag, ".rdata"},      bus.resp_rdata, exp_d);
      chk({tag, ".ready_back"}, {bus.req_ready, bus.mem_rd_req}, 2'b10);
    end
    tick();
    chk({tag, ".pulse_end"}, bus.resp_valid, 0);
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic exp_hit);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    chk({tag, ".req_ready"}, bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    chk({tag, ".mem_req"},   {bus.mem_wr_req, bus.mem_rd_req, bus.resp_valid}, 3'b100);
    chk({tag, ".mem_addr"},  bus.mem_addr, a);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, d);
    mem_serve();
    chk({tag, ".resp_valid"}, bus.resp_valid, 1);
    chk({tag, ".resp_hit"},   bus.resp_hit, exp_hit);
    chk({tag, ".rdata"},      bus.resp_rdata, 0);
    tick();
    chk({tag, ".pulse_end"}, bus.resp_valid, 0);
  endtask

  logic [15:0] b2b_addr [4];
  logic [15:0] b2b_data [4];

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i) + 16'h00C0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;

    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready",  bus.req_ready, 1);
    chk("rst.resp",       {bus.resp_valid, bus.resp_hit, bus.resp_rdata}, 18'h0);
    chk("rst.mem_req",    {bus.mem_rd_req, bus.mem_wr_req}, 2'b00);
    chk("rst.mem_bus",    {bus.mem_addr, bus.mem_wdata}, 32'h0);
    chk("rst.counters",   {access_cnt, hit_cnt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    do_read("rd_0010_miss", 16'h0010, 1'b0, 16'h00D0, 0);
    do_read("rd_0012_hit",  16'h0012, 1'b1, 16'h00D2, 0);
    do_read("rd_0020_miss", 16'h0020, 1'b0, 16'h00E0, 0);
    do_read("rd_0010_mru",  16'h0010, 1'b1, 16'h00D0, 0);
    do_read("rd_0030_slow", 16'h0030, 1'b0, 16'h00F0, 5);
    do_read("rd_0010_keep", 16'h0010, 1'b1, 16'h00D0, 0);
    do_read("rd_0020_evct", 16'h0020, 1'b0, 16'h00E0, 0);

    do_write("wr_0011_hit",  16'h0011, 16'hBEEF, 1'b1);
    do_read ("rd_0011_hit",  16'h0011, 1'b1, 16'hBEEF, 0);
    do_write("wr_0400_miss", 16'h0400, 16'h1234, 1'b0);
    do_read ("rd_0400_miss", 16'h0400, 1'b0, 16'h1234, 0);

    // Reset while a refill is outstanding.
    bus.req_valid = 1'b1;
    bus.req_addr  = 16'h0050;
    tick();
    bus.req_valid = 1'b0;
    chk("rstmid.mem_rd_req", bus.mem_rd_req, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstmid.drop", {bus.mem_rd_req, bus.resp_valid}, 2'b00);
    tick();
    chk("rstmid.no_resp", bus.resp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    chk("idle_mem_ready", {bus.resp_valid, bus.req_ready, bus.mem_rd_req}, 3'b010);

    do_read("rd_0012_inval", 16'h0012, 1'b0, 16'h00D2, 0);
    do_read("rd_0050_inval", 16'h0050, 1'b0, 16'h0110, 0);

    // Four back-to-back hits, one per cycle.
    b2b_addr = '{16'h0013, 16'h0010, 16'h0051, 16'h0052};
    b2b_data = '{16'h00D3, 16'h00D0, 16'h0111, 16'h0112};
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = b2b_addr[i];
      chk($sformatf("b2b%0d.req_ready", i), bus.req_ready, 1);
      tick();
      chk($sformatf("b2b%0d.resp", i), {bus.resp_valid, bus.resp_hit, bus.resp_rdata},
          {2'b11, b2b_data[i]});
    end
    bus.req_valid = 1'b0;
    tick();
    chk("b2b.pulse_end", bus.resp_valid, 0);

`ifdef ASSOC_CACHE_STATS_EN
    chk("stats.access_cnt", access_cnt, 16'd6);
    chk("stats.hit_cnt",    hit_cnt,    16'd4);
`else
    chk("stats.access_cnt", access_cnt, 16'd0);
    chk("stats.hit_cnt",    hit_cnt,    16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
